// File: rtl/wsn_air_channel_pkg.sv
// Shared definitions for the radio medium model: air-sample field layout and defaults.
package wsn_air_channel_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 32'd1000000;

  localparam int VALID_OFS   = 0;
  localparam int COL_OFS     = 1;
  localparam int BIT_OFS     = 2;
  localparam int SRCMASK_OFS = 3;

  // Per-source bits ride behind the source mask so each receiver ORs only what it can hear.
  function automatic int srcbits_ofs(input int n);
    return SRCMASK_OFS + n;
  endfunction

  function automatic int sample_w(input int n);
    return 3 + 2 * n;
  endfunction

endpackage

// File: rtl/wsn_air_channel_delay_line.sv
// W-bit, DEPTH-stage shift register with synchronous clear; every stage is exposed as a tap.
module wsn_air_channel_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       din,
  output logic [DEPTH*W-1:0] taps
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    assign taps[k*W +: W] = stage[k];
  end

endmodule

// File: rtl/wsn_air_channel.sv
// Shared radio medium: delayed per-receiver delivery, carrier sense, collision count, trap/timeout end-of-sim.
module wsn_air_channel
  import wsn_air_channel_pkg::*;
#(
  parameter int                           N_NODES   = 2,
  parameter int                           DELAY     = 4,
  parameter logic [N_NODES*N_NODES-1:0]   LINK_MASK = '1,
  parameter int unsigned                  TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int                           CNT_W     = 16,
  localparam int                          ID_W      = $clog2(N_NODES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_NODES-1:0] tx_en_i,
  input  logic [N_NODES-1:0] tx_bit_i,
  output logic [N_NODES-1:0] rx_valid_o,
  output logic [N_NODES-1:0] rx_bit_o,
  output logic [N_NODES-1:0] rx_col_o,
  output logic [N_NODES-1:0] cs_o,
  output logic [CNT_W-1:0]   col_cnt_o,
  input  logic [N_NODES-1:0] trap_i,
  output logic               trap_vld_o,
  output logic [ID_W-1:0]    trap_id_o,
  output logic               timeout_o,
  output logic               done_o
);

  localparam int SW = sample_w(N_NODES);
  localparam int SB = srcbits_ofs(N_NODES);

  function automatic logic multi(input logic [N_NODES-1:0] v);
    return (v & (v - N_NODES'(1))) != '0;
  endfunction

  int                    n_tx;
  logic [SW-1:0]         launch;
  logic [DELAY*SW-1:0]   taps;
  logic [SW-1:0]         arrive;
  logic [N_NODES-1:0]    cs_next;
  logic [ID_W-1:0]       first_id;
  logic                  capture;
  logic                  tmo_hit;
  logic [31:0]           tmo_cnt;
  logic                  unused_taps;

  // Launch: build the air sample for this cycle
  always_comb begin
    n_tx = 0;
    for (int j = 0; j < N_NODES; j++) n_tx = n_tx + int'(tx_en_i[j]);
    launch                         = '0;
    launch[VALID_OFS]              = |tx_en_i;
    launch[COL_OFS]                = (n_tx >= 2);
    launch[BIT_OFS]                = |(tx_en_i & tx_bit_i);
    launch[SRCMASK_OFS +: N_NODES] = tx_en_i;
    launch[SB +: N_NODES]          = tx_en_i & tx_bit_i;
  end

  wsn_air_channel_delay_line #(.W(SW), .DEPTH(DELAY)) u_air (
    .clk   (clk),
    .reset (reset),
    .din   (launch),
    .taps  (taps)
  );

  assign arrive      = taps[(DELAY-1)*SW +: SW];
  assign unused_taps = ^taps;

  // Delivery and carrier sense, one slice per receiver
  for (genvar i = 0; i < N_NODES; i++) begin : g_rx
    localparam logic [N_NODES-1:0] HEAR = LINK_MASK[i*N_NODES +: N_NODES] & ~(N_NODES'(1) << i);
    logic [N_NODES-1:0] aud_src;
    logic [N_NODES-1:0] aud_bits;
    logic               cs_d;

    assign aud_src       = arrive[SRCMASK_OFS +: N_NODES] & HEAR;
    assign aud_bits      = arrive[SB +: N_NODES] & HEAR;
    assign rx_valid_o[i] = arrive[VALID_OFS] & (|aud_src);
    assign rx_bit_o[i]   = rx_valid_o[i] & (|aud_bits);
    assign rx_col_o[i]   = rx_valid_o[i] & (multi(aud_src) | tx_en_i[i]);

    always_comb begin
      cs_d = |(tx_en_i & HEAR);
      for (int k = 0; k < DELAY; k++) begin
        if (taps[k*SW + VALID_OFS] && ((taps[k*SW + SRCMASK_OFS +: N_NODES] & HEAR) != '0))
          cs_d = 1'b1;
      end
    end
    assign cs_next[i] = cs_d;
  end

  always_comb begin
    first_id = '0;
    for (int j = N_NODES - 1; j >= 0; j--) begin
      if (trap_i[j]) first_id = ID_W'(j);
    end
  end

  // A trap landing on the timeout cycle wins; the timeout is suppressed.
  assign capture = ~trap_vld_o & (|trap_i);
  assign tmo_hit = (TIMEOUT != 0) && !done_o && !capture && (tmo_cnt == TIMEOUT - 1);

  // Registered status: carrier sense, collision count, end-of-simulation flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_o       <= '0;
      col_cnt_o  <= '0;
      trap_vld_o <= 1'b0;
      trap_id_o  <= '0;
      timeout_o  <= 1'b0;
      done_o     <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      cs_o <= cs_next;
      if (n_tx >= 2 && col_cnt_o != '1) col_cnt_o <= col_cnt_o + CNT_W'(1);
      if (capture) begin
        trap_vld_o <= 1'b1;
        trap_id_o  <= first_id;
      end
      if (tmo_hit) timeout_o <= 1'b1;
      if (capture || tmo_hit) done_o <= 1'b1;
      if (!done_o) tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_wsn_air_channel.sv
// Directed and randomized checks of the air channel against a timestamped-queue reference model.
module tb_wsn_air_channel;

  localparam int N   = 3;
  localparam int D   = 4;
  localparam int TMO = 50;
  localparam logic [N*N-1:0] LM = 9'b111_111_011;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic [N-1:0] tx_en  = '0;
  logic [N-1:0] tx_bit = '0;
  logic [N-1:0] trap   = '0;
  logic [N-1:0] rx_valid, rx_bit, rx_col, cs;
  logic [15:0]  col_cnt;
  logic         trap_vld;
  logic [1:0]   trap_id;
  logic         timeout, done;

  int errors = 0;
  int checks = 0;

  wsn_air_channel #(
    .N_NODES(N), .DELAY(D), .LINK_MASK(LM), .TIMEOUT(TMO), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .tx_en_i(tx_en), .tx_bit_i(tx_bit),
    .rx_valid_o(rx_valid), .rx_bit_o(rx_bit), .rx_col_o(rx_col), .cs_o(cs),
    .col_cnt_o(col_cnt), .trap_i(trap), .trap_vld_o(trap_vld), .trap_id_o(trap_id),
    .timeout_o(timeout), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           t;
    logic [N-1:0] en;
    logic [N-1:0] b;
  } samp_t;

  samp_t        q[$];
  int           now   = 0;
  int           col_m = 0;
  logic [N-1:0] cs_m  = '0;
  logic         tv_m  = 1'b0;
  logic         to_m  = 1'b0;
  int           id_m  = 0;
  int           since = 0;

  function automatic logic [N-1:0] hear(input int i);
    logic [N*N-1:0] lm;
    logic [N-1:0]   row;
    lm     = LM;
    row    = lm[i*N +: N];
    row[i] = 1'b0;
    return row;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] ev, eb, ec, a;
    logic         found;
    samp_t        s;
    ev = '0; eb = '0; ec = '0; found = 1'b0;
    foreach (q[k]) if (q[k].t == now - D) begin s = q[k]; found = 1'b1; end
    if (found) begin
      for (int i = 0; i < N; i++) begin
        a     = s.en & hear(i);
        ev[i] = (a != '0);
        eb[i] = |(s.b & a);
        ec[i] = ev[i] && (($countones(a) >= 2) || tx_en[i]);
      end
    end
    chk("rx_valid", 32'(rx_valid), 32'(ev));
    chk("rx_bit",   32'(rx_bit),   32'(eb));
    chk("rx_col",   32'(rx_col),   32'(ec));
    chk("cs",       32'(cs),       32'(cs_m));
    chk("col_cnt",  32'(col_cnt),  32'(col_m));
    chk("trap_vld", 32'(trap_vld), 32'(tv_m));
    chk("trap_id",  32'(trap_id),  32'(id_m));
    chk("timeout",  32'(timeout),  32'(to_m));
    chk("done",     32'(done),     32'(tv_m | to_m));
  endtask

  task automatic look(input logic [N-1:0] en, input logic [N-1:0] b,
                      input logic [N-1:0] tr, input logic rs);
    tx_en = en; tx_bit = b; trap = tr; reset = rs;
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    logic [N-1:0] csn;
    logic         was_done;
    @(posedge clk);
    if (reset) begin
      q.delete();
      cs_m = '0; col_m = 0; tv_m = 1'b0; to_m = 1'b0; id_m = 0; since = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        csn[i] = |(tx_en & hear(i));
        foreach (q[k]) if (q[k].t >= now - D && (q[k].en & hear(i)) != '0) csn[i] = 1'b1;
      end
      cs_m = csn;
      if ($countones(tx_en) >= 2 && col_m < 65535) col_m++;
      was_done = tv_m | to_m;
      if (!tv_m && trap != '0) begin
        tv_m = 1'b1;
        for (int j = N - 1; j >= 0; j--) if (trap[j]) id_m = j;
      end else if (!was_done && since == TMO - 1) begin
        to_m = 1'b1;
      end
      if (!was_done) since++;
      q.push_back('{now, tx_en, tx_bit});
      while (q.size() > 0 && q[0].t <= now - D) void'(q.pop_front());
    end
    now++;
    #1;
  endtask

  task automatic step(input logic [N-1:0] en, input logic [N-1:0] b,
                      input logic [N-1:0] tr, input logic rs);
    look(en, b, tr, rs);
    advance();
  endtask

  initial begin
    logic [N-1:0] ren, rb, rtr;
    logic         rrs;

    look('0, '0, '0, 1'b1);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_col_cnt",  32'(col_cnt),  32'd0);
    chk("reset_done",     32'(done),     32'd0);
    advance();
    repeat (2) step('0, '0, '0, 1'b1);

    // Single sender: node 0 heard by 1 and 2 after DELAY
    repeat (3) step('0, '0, '0, 1'b0);
    step(3'b001, 3'b001, '0, 1'b0);
    repeat (3) step('0, '0, '0, 1'b0);
    look('0, '0, '0, 1'b0);
    chk("t1_rx_valid", 32'(rx_valid), 32'b110);
    chk("t1_rx_bit",   32'(rx_bit),   32'b110);
    advance();
    repeat (3) step('0, '0, '0, 1'b0);

    // Nodes 0 and 2 collide; node 1 hears both, node 0 cannot hear node 2
    step('0, '0, '0, 1'b1);
    repeat (2) step('0, '0, '0, 1'b0);
    step(3'b101, 3'b100, '0, 1'b0);
    look('0, '0, '0, 1'b0);
    chk("t2_col_cnt", 32'(col_cnt), 32'd1);
    advance();
    repeat (2) step('0, '0, '0, 1'b0);
    look('0, '0, '0, 1'b0);
    chk("t2_rx_valid", 32'(rx_valid), 32'b110);
    chk("t2_rx_col",   32'(rx_col),   32'b010);
    chk("t2_rx_bit",   32'(rx_bit),   32'b010);
    advance();

    // Node 2 is hidden from node 0
    step(3'b100, 3'b100, '0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      look('0, '0, '0, 1'b0);
      chk("t3_cs0", 32'(cs[0]), 32'd0);
      if (k == 4) chk("t3_rx_valid", 32'(rx_valid), 32'b010);
      advance();
    end

    // Simultaneous traps resolve to the lowest index; later traps ignored
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b0);
    step('0, '0, 3'b110, 1'b0);
    look('0, '0, '0, 1'b0);
    chk("t4_trap_vld", 32'(trap_vld), 32'd1);
    chk("t4_trap_id",  32'(trap_id),  32'd1);
    chk("t4_done",     32'(done),     32'd1);
    advance();
    step('0, '0, 3'b001, 1'b0);
    look('0, '0, '0, 1'b0);
    chk("t4_trap_id_kept", 32'(trap_id), 32'd1);
    advance();

    // Timeout exactly TMO cycles after reset release
    step('0, '0, '0, 1'b1);
    for (int k = 0; k <= 51; k++) begin
      look('0, '0, '0, 1'b0);
      if (k == 49) chk("t5_timeout_early", 32'(timeout), 32'd0);
      if (k == 50) begin
        chk("t5_timeout",  32'(timeout),  32'd1);
        chk("t5_done",     32'(done),     32'd1);
        chk("t5_trap_vld", 32'(trap_vld), 32'd0);
      end
      advance();
    end

    // Trap on the timeout cycle wins
    step('0, '0, '0, 1'b1);
    repeat (49) step('0, '0, '0, 1'b0);
    step('0, '0, 3'b010, 1'b0);
    look('0, '0, '0, 1'b0);
    chk("tt_trap_vld", 32'(trap_vld), 32'd1);
    chk("tt_timeout",  32'(timeout),  32'd0);
    advance();
    repeat (3) step('0, '0, '0, 1'b0);

    // Reset while samples are in flight
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b0);
    step(3'b011, 3'b011, '0, 1'b0);
    step(3'b001, 3'b001, '0, 1'b0);
    step('0, '0, '0, 1'b1);
    look('0, '0, '0, 1'b0);
    chk("t6_col_cnt", 32'(col_cnt), 32'd0);
    chk("t6_cs",      32'(cs),      32'd0);
    advance();
    for (int k = 0; k < 8; k++) begin
      look('0, '0, '0, 1'b0);
      chk("t6_rx_valid", 32'(rx_valid), 32'd0);
      advance();
    end

    // Randomized traffic with occasional traps and resets
    step('0, '0, '0, 1'b1);
    repeat (400) begin
      ren = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 7));
      rb  = N'($urandom_range(0, 7));
      rtr = (!to_m && $urandom_range(0, 29) == 0) ? N'($urandom_range(1, 7)) : '0;
      rrs = ($urandom_range(0, 79) == 0);
      step(ren, rb, rtr, rrs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
